fetch: RTL and testbench

- Fetch stage of the sequential (SEQ) Y86-64 processor.
- Takes the current PC and a 10-byte instruction window starting at that PC, and splits it into icode, ifun, rA, rB and valC.
- Computes the fall-through address valP and raises the halt, invalid-instruction and instruction-memory-error status flags.
- Feeds the decode stage. All outputs are registered on the single system clock.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/fetch_len_decode.sv | 62 ++++++
 rtl/fetch.sv | 91 +++++++++
 tb/tb_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" marker and
// the legal ifun ranges for ALU and condition-code instructions.
package y86_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,  // also CMOVXX
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;

  // OPq uses ifun 0..3 (add, sub, and, xor).
  localparam logic [3:0] ALU_FUN_MAX  = 4'd3;
  // CMOVXX / JXX use ifun 0..6 (always, le, l, e, ne, ge, g).
  localparam logic [3:0] COND_FUN_MAX = 4'd6;

endpackage

// File: rtl/fetch_len_decode.sv
// Combinational instruction-format decode.
//   icode, ifun  : upper / lower nibble of instruction byte 0
//   need_regids  : instruction carries a register-specifier byte
//   need_valc    : instruction carries an 8-byte constant
//   length       : instruction length in bytes (1 for an invalid encoding)
//   valid        : icode/ifun combination is legal
// need_regids/need_valc depend on icode only, so field extraction stays
// independent of the validity check.
module fetch_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic       need_regids,
  output logic       need_valc,
  output logic [3:0] length,
  output logic       valid
);

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    valid       = 1'b0;
    case (icode_e'(icode))
      IHALT, INOP, IRET: valid = (ifun == 4'd0);
      IRRMOVQ: begin
        need_regids = 1'b1;
        valid       = (ifun <= COND_FUN_MAX);
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
        valid       = (ifun == 4'd0);
      end
      IOPQ: begin
        need_regids = 1'b1;
        valid       = (ifun <= ALU_FUN_MAX);
      end
      IJXX: begin
        need_valc = 1'b1;
        valid     = (ifun <= COND_FUN_MAX);
      end
      ICALL: begin
        need_valc = 1'b1;
        valid     = (ifun == 4'd0);
      end
      IPUSHQ, IPOPQ: begin
        need_regids = 1'b1;
        valid       = (ifun == 4'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    if (valid)
      length = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
    else
      length = 4'd1;
  end

endmodule

// File: rtl/fetch.sv
// SEQ Y86-64 fetch stage. Splits a 10-byte instruction window into its
// fields, computes the fall-through PC and status flags, all registered.
//   clk, rst_n     : clock, synchronous active-low reset
//   PC             : address of the current instruction
//   instr[0:79]    : instruction bytes at PC, byte k = instr[8k:8k+7]
//   icode, ifun    : byte 0 nibbles
//   ra, rb         : register specifiers (RNONE if no register byte)
//   valC           : little-endian constant (0 if none)
//   valP           : PC + instruction length (PC+1 if invalid), wraps
//   imem_error     : PC outside instruction memory
//   instr_invalid  : illegal icode/ifun combination
//   HLT            : valid halt fetched from a legal address
module fetch
  import y86_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] PC,
  input  logic [0:79] instr,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        imem_error,
  output logic        instr_invalid,
  output logic        HLT
);

  logic [3:0]  icode_d, ifun_d, ra_d, rb_d, length;
  logic [63:0] valc_d;
  logic        need_regids, need_valc, valid, imem_err_d;

  assign icode_d = instr[0:3];
  assign ifun_d  = instr[4:7];

  fetch_len_decode u_len (
    .icode       (icode_d),
    .ifun        (ifun_d),
    .need_regids (need_regids),
    .need_valc   (need_valc),
    .length      (length),
    .valid       (valid)
  );

  assign ra_d       = need_regids ? instr[8:11]  : RNONE;
  assign rb_d       = need_regids ? instr[12:15] : RNONE;
  assign imem_err_d = (PC >= 64'(IMEM_SIZE));

  // The constant starts right after the register byte when there is one,
  // otherwise right after byte 0; bytes are assembled little-endian.
  always_comb begin
    valc_d = '0;
    if (need_valc) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (need_regids)
          valc_d[8*k +: 8] = instr[8*(k+2) +: 8];
        else
          valc_d[8*k +: 8] = instr[8*(k+1) +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icode         <= '0;
      ifun          <= '0;
      ra            <= RNONE;
      rb            <= RNONE;
      valC          <= '0;
      valP          <= '0;
      imem_error    <= 1'b0;
      instr_invalid <= 1'b0;
      HLT           <= 1'b0;
    end else begin
      icode         <= icode_d;
      ifun          <= ifun_d;
      ra            <= ra_d;
      rb            <= rb_d;
      valC          <= valc_d;
      valP          <= PC + 64'(length);
      imem_error    <= imem_err_d;
      instr_invalid <= ~valid;
      HLT           <= (icode_d == IHALT) && valid && !imem_err_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam int unsigned IMEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] PC;
  logic [0:79] instr;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valC, valP;
  logic        imem_error, instr_invalid, HLT;

  fetch #(.IMEM_SIZE(IMEM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC            (PC),
    .instr         (instr),
    .icode         (icode),
    .ifun          (ifun),
    .ra            (ra),
    .rb            (rb),
    .valC          (valC),
    .valP          (valP),
    .imem_error    (imem_error),
    .instr_invalid (instr_invalid),
    .HLT           (HLT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        imem, inv, hlt;
  } exp_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: instruction formats from per-icode tables.
  function automatic exp_t model(input logic [63:0] pc, input logic [0:79] ins);
    exp_t e;
    logic [7:0] b [10];
    int unsigned len [12]    = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
    int unsigned maxfun [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};
    int unsigned ic, fn;
    for (int i = 0; i < 10; i++) b[i] = ins[8*i +: 8];
    ic = int'(b[0][7:4]);
    fn = int'(b[0][3:0]);
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    e.inv   = (ic > 11) || (fn > maxfun[ic % 12]);
    e.imem  = (pc >= 64'(IMEM));
    e.hlt   = (ic == 0) && (fn == 0) && !e.imem;
    if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
      e.ra = b[1][7:4];
      e.rb = b[1][3:0];
    end else begin
      e.ra = 4'hF;
      e.rb = 4'hF;
    end
    e.valc = 0;
    if (ic inside {3, 4, 5})
      for (int k = 0; k < 8; k++) e.valc = e.valc | (64'(b[2+k]) << (8*k));
    else if (ic inside {7, 8})
      for (int k = 0; k < 8; k++) e.valc = e.valc | (64'(b[1+k]) << (8*k));
    e.valp = pc + 64'(e.inv ? 1 : len[ic]);
    return e;
  endfunction

  function automatic exp_t reset_val();
    exp_t e;
    e.icode = 0; e.ifun = 0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = 0; e.valp = 0; e.imem = 0; e.inv = 0; e.hlt = 0;
    return e;
  endfunction

  exp_t exp_q;
  logic have_exp = 1'b0;

  always @(posedge clk) begin
    exp_q    <= rst_n ? model(PC, instr) : reset_val();
    have_exp <= 1'b1;
  end

  always @(negedge clk) begin
    if (have_exp) begin
      check("icode", 64'(icode), 64'(exp_q.icode));
      check("ifun", 64'(ifun), 64'(exp_q.ifun));
      check("ra", 64'(ra), 64'(exp_q.ra));
      check("rb", 64'(rb), 64'(exp_q.rb));
      check("valC", valC, exp_q.valc);
      check("valP", valP, exp_q.valp);
      check("imem_error", 64'(imem_error), 64'(exp_q.imem));
      check("instr_invalid", 64'(instr_invalid), 64'(exp_q.inv));
      check("HLT", 64'(HLT), 64'(exp_q.hlt));
    end
  end

  task automatic apply(input logic [63:0] pc, input logic [0:79] ins);
    @(posedge clk);
    #1;
    PC    = pc;
    instr = ins;
  endtask

  // Wait until the applied vector has been registered, then sample.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  logic [0:79] v;

  initial begin
    rst_n = 1'b0;
    PC    = 64'd0;
    instr = 80'h00AD7392650AB73E8BCE;
    repeat (2) @(posedge clk);
    #2;
    check("rst icode", 64'(icode), 64'd0);
    check("rst ra", 64'(ra), 64'hF);
    check("rst rb", 64'(rb), 64'hF);
    check("rst valP", valP, 64'd0);
    check("rst HLT", 64'(HLT), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    apply(64'd0, 80'h00AD7392650AB73E8BCE);
    settle();
    check("halt HLT", 64'(HLT), 64'd1);
    check("halt valP", valP, 64'd1);
    check("halt ra", 64'(ra), 64'hF);
    check("halt valC", valC, 64'd0);

    apply(64'd0, 80'h3075239BCE834DAB49EC);
    settle();
    check("irmovq ra", 64'(ra), 64'd7);
    check("irmovq rb", 64'(rb), 64'd5);
    check("irmovq valC", valC, 64'hEC49AB4D83CE9B23);
    check("irmovq valP", valP, 64'd10);

    apply(64'd0, 80'h708EF729CBA74D6C92BC);
    settle();
    check("jxx ifun", 64'(ifun), 64'd0);
    check("jxx rb", 64'(rb), 64'hF);
    check("jxx valC", valC, 64'h926C4DA7CB29F78E);
    check("jxx valP", valP, 64'd9);

    apply(64'd0, 80'h268BC9EAB567CD742EC2);
    settle();
    check("cmov ra", 64'(ra), 64'd8);
    check("cmov rb", 64'(rb), 64'hB);
    check("cmov valP", valP, 64'd2);
    check("cmov inv", 64'(instr_invalid), 64'd0);

    apply(64'd0, 80'hA18CECBD5B375A85C869);
    settle();
    check("pushq-bad inv", 64'(instr_invalid), 64'd1);
    check("pushq-bad HLT", 64'(HLT), 64'd0);
    check("pushq-bad valP", valP, 64'd1);

    apply(64'd0, 80'h64123456789ABCDEF012);
    settle();
    check("opq-bad inv", 64'(instr_invalid), 64'd1);
    check("opq-bad valP", valP, 64'd1);

    apply(64'd0, 80'hC0123456789ABCDEF012);
    settle();
    check("icodeC inv", 64'(instr_invalid), 64'd1);
    check("icodeC valP", valP, 64'd1);

    apply(64'(IMEM), 80'h10000000000000000000);
    settle();
    check("oob imem", 64'(imem_error), 64'd1);
    check("oob HLT", 64'(HLT), 64'd0);
    check("oob valP", valP, 64'(IMEM + 1));

    apply(64'(IMEM - 1), 80'h00000000000000000000);
    settle();
    check("last-byte imem", 64'(imem_error), 64'd0);
    check("last-byte HLT", 64'(HLT), 64'd1);

    apply(64'hFFFF_FFFF_FFFF_FFFF, 80'h3075239BCE834DAB49EC);
    settle();
    check("wrap valP", valP, 64'd9);
    check("wrap imem", 64'(imem_error), 64'd1);

    // Both error flags together.
    apply(64'd5000, 80'h0F000000000000000000);
    settle();
    check("both imem", 64'(imem_error), 64'd1);
    check("both inv", 64'(instr_invalid), 64'd1);

    // Reset overrides a live decode for one edge.
    apply(64'd0, 80'h3075239BCE834DAB49EC);
    rst_n = 1'b0;
    settle();
    check("midrst valC", valC, 64'd0);
    check("midrst ra", 64'(ra), 64'hF);
    #0 rst_n = 1'b1;
    settle();
    check("postrst valC", valC, 64'hEC49AB4D83CE9B23);

    // Every byte-0 value at a few addresses, checked by the model.
    for (int i = 0; i < 256; i++) begin
      v = 80'h00_5A_13_57_9B_DF_24_68_AC_E1;
      v[0:7] = 8'(i);
      apply(64'(i * 37), v);
    end
    apply(64'(IMEM - 2), 80'h8012345678_9ABCDEF0_11);
    apply(64'd100, 80'hB0F3FFFFFFFFFFFFFFFF);
    apply(64'd0, 80'h0000000000000000000_0);
    repeat (2) @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
